// File: rtl/sfq_xor_driver.sv
// Host-side driver/decoder for a toggle-encoded RSFQ XOR cell.
// Fires a, b and clk toggle pulses with programmed spacing, then decodes the
// q toggle response into a result bit and compares it against a^b.
module sfq_xor_driver #(
   parameter int unsigned GAP_CYC     = 2,
   parameter int unsigned RESP_CYC    = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_a,
   input  logic             in_b,
   output logic             a_out,
   output logic             b_out,
   output logic             clk_out,
   input  logic             q_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_result,
   output logic             out_mismatch,
   output logic             stray_err,
   output logic [CNT_W-1:0] tx_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned TMR_MAX = (GAP_CYC > RESP_CYC) ? GAP_CYC : RESP_CYC;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIRE_A,
      S_FIRE_B,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t                 state;
   logic [TMR_W-1:0]       tmr;
   logic                   a_bit;
   logic                   b_bit;
   logic                   q_ref;
   logic [SYNC_STAGES-1:0] q_sync_r;
   logic                   q_sync;
   logic                   q_toggled_c;
   logic                   result_c;

   assign q_sync      = q_sync_r[SYNC_STAGES-1];
   assign q_toggled_c = q_sync ^ q_ref;
   assign result_c    = q_toggled_c;

   // Bring the asynchronous cell output into the host clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_sync_r <= '0;
      end else begin
         q_sync_r <= (q_sync_r << 1) | SYNC_STAGES'(q_in);
      end
   end

   // Transaction sequencer: fire pulses, judge the response window, hold result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         tmr          <= '0;
         a_bit        <= 1'b0;
         b_bit        <= 1'b0;
         q_ref        <= 1'b0;
         in_ready     <= 1'b1;
         a_out        <= 1'b0;
         b_out        <= 1'b0;
         clk_out      <= 1'b0;
         out_valid    <= 1'b0;
         out_result   <= 1'b0;
         out_mismatch <= 1'b0;
         stray_err    <= 1'b0;
         tx_count     <= '0;
         err_count    <= '0;
      end else begin
         // Any q activity outside the response window is a stray pulse; resync
         // the reference so the next window is still judged correctly.
         if (state != S_WAIT && q_toggled_c) begin
            stray_err <= 1'b1;
            q_ref     <= q_sync;
         end

         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  a_bit    <= in_a;
                  b_bit    <= in_b;
                  if (in_a) a_out <= ~a_out;
                  in_ready <= 1'b0;
                  tmr      <= TMR_W'(GAP_CYC);
                  state    <= S_FIRE_A;
               end
            end

            S_FIRE_A: begin
               if (tmr == TMR_W'(1)) begin
                  if (b_bit) b_out <= ~b_out;
                  tmr   <= TMR_W'(GAP_CYC);
                  state <= S_FIRE_B;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end

            S_FIRE_B: begin
               if (tmr == TMR_W'(1)) begin
                  clk_out <= ~clk_out;
                  tmr     <= TMR_W'(RESP_CYC);
                  state   <= S_WAIT;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end

            S_WAIT: begin
               if (tmr == TMR_W'(1)) begin
                  out_result   <= result_c;
                  out_mismatch <= result_c ^ (a_bit ^ b_bit);
                  q_ref        <= q_sync;
                  tx_count     <= tx_count + CNT_W'(1);
                  if (result_c ^ (a_bit ^ b_bit)) err_count <= err_count + CNT_W'(1);
                  out_valid    <= 1'b1;
                  state        <= S_HOLD;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end

            S_HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfq_xor_driver.sv
// Bench for sfq_xor_driver: behavioural XOR cell model plus expectations
// derived from pulse timing rules and the a^b truth table.
module tb_sfq_xor_driver;

   localparam int unsigned G1 = 2, R1 = 4;
   localparam int unsigned G2 = 1, R2 = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0, out_ready = 1'b1, q_in = 1'b0;
   logic in_ready, a_out, b_out, clk_out, out_valid, out_result, out_mismatch, stray_err;
   logic [15:0] tx_count, err_count;

   logic in_valid2 = 1'b0, in_a2 = 1'b0, in_b2 = 1'b0, out_ready2 = 1'b1, q_in2 = 1'b0;
   logic in_ready2, a_out2, b_out2, clk_out2, out_valid2, out_result2, out_mismatch2, stray_err2;
   logic [15:0] tx_count2, err_count2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [15:0] exp_tx = '0, exp_err = '0;
   logic a_lvl = 1'b0;
   bit faulty = 1'b0;
   int stray_req = 0, stray_done = 0;

   sfq_xor_driver #(.GAP_CYC(G1), .RESP_CYC(R1), .SYNC_STAGES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .a_out(a_out), .b_out(b_out), .clk_out(clk_out), .q_in(q_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_mismatch(out_mismatch),
      .stray_err(stray_err), .tx_count(tx_count), .err_count(err_count));

   sfq_xor_driver #(.GAP_CYC(G2), .RESP_CYC(R2), .SYNC_STAGES(2), .CNT_W(16)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
      .a_out(a_out2), .b_out(b_out2), .clk_out(clk_out2), .q_in(q_in2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_result(out_result2), .out_mismatch(out_mismatch2),
      .stray_err(stray_err2), .tx_count(tx_count2), .err_count(err_count2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Toggle-encoded XOR cell: a/b pulses flip the internal state, a clk pulse
   // emits a q toggle when the state is 1 and clears it.
   logic c1_st = 1'b0, c1_pa = 1'b0, c1_pb = 1'b0, c1_pc = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         c1_st = 1'b0; q_in = 1'b0; c1_pa = 1'b0; c1_pb = 1'b0; c1_pc = 1'b0;
      end else begin
         if (a_out !== c1_pa) c1_st = ~c1_st;
         if (b_out !== c1_pb) c1_st = ~c1_st;
         if (clk_out !== c1_pc) begin
            if (c1_st && !faulty) q_in = ~q_in;
            c1_st = 1'b0;
         end
         c1_pa = a_out; c1_pb = b_out; c1_pc = clk_out;
         if (stray_req != stray_done) begin
            q_in = ~q_in;
            stray_done = stray_req;
         end
      end
   end

   // Second cell instance for the fast-timing driver.
   logic c2_st = 1'b0, c2_pa = 1'b0, c2_pb = 1'b0, c2_pc = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         c2_st = 1'b0; q_in2 = 1'b0; c2_pa = 1'b0; c2_pb = 1'b0; c2_pc = 1'b0;
      end else begin
         if (a_out2 !== c2_pa) c2_st = ~c2_st;
         if (b_out2 !== c2_pb) c2_st = ~c2_st;
         if (clk_out2 !== c2_pc) begin
            if (c2_st) q_in2 = ~q_in2;
            c2_st = 1'b0;
         end
         c2_pa = a_out2; c2_pb = b_out2; c2_pc = clk_out2;
      end
   end

   task automatic step;
      @(posedge clk); #1;
   endtask

   // Offer one pair to the main driver and record the cycle index (1 = first
   // sample after the accept edge) at which each line first changes.
   task automatic run_txn(input bit a, input bit b, output int ia, output int ib,
                          output int ic, output int iv, output bit res, output bit mm);
      logic pa, pb, pc;
      ia = -1; ib = -1; ic = -1; iv = -1; res = 1'b0; mm = 1'b0;
      pa = a_out; pb = b_out; pc = clk_out;
      in_valid = 1'b1; in_a = a; in_b = b;
      step();
      in_valid = 1'b0; in_a = 1'($urandom); in_b = 1'($urandom);
      for (int k = 1; k <= 40 && iv < 0; k++) begin
         if (a_out !== pa && ia < 0) ia = k;
         if (b_out !== pb && ib < 0) ib = k;
         if (clk_out !== pc && ic < 0) ic = k;
         if (out_valid === 1'b1) begin
            iv = k; res = out_result; mm = out_mismatch;
         end
         pa = a_out; pb = b_out; pc = clk_out;
         if (iv < 0) step();
      end
      if (iv >= 0) begin
         a_lvl = a_lvl ^ a;
         exp_tx = exp_tx + 16'd1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) step();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
      n_cmp++; if ({a_out, b_out, clk_out} !== 3'b000) begin n_bad++; $display("FAIL rst_lines got %b want 000", {a_out, b_out, clk_out}); end
      n_cmp++; if ({out_valid, out_result, out_mismatch, stray_err} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b want 0000", {out_valid, out_result, out_mismatch, stray_err}); end
      n_cmp++; if (tx_count !== 16'd0 || err_count !== 16'd0) begin n_bad++; $display("FAIL rst_counts got %0d/%0d want 0/0", tx_count, err_count); end
      n_cmp++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin n_bad++; $display("FAIL rst_dut2 got ready %0b valid %0b want 1 0", in_ready2, out_valid2); end
      rst = 1'b0;
      repeat (2) step();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_basic;
      bit a, b, res, mm;
      int ia, ib, ic, iv;
      out_ready = 1'b1;
      for (int t = 0; t < 10; t++) begin
         case (t)
            0: begin a = 1'b1; b = 1'b0; end
            1: begin a = 1'b0; b = 1'b1; end
            2: begin a = 1'b1; b = 1'b1; end
            3: begin a = 1'b0; b = 1'b0; end
            default: begin a = 1'($urandom); b = 1'($urandom); end
         endcase
         run_txn(a, b, ia, ib, ic, iv, res, mm);
         n_cmp++; if (ia !== (a ? 1 : -1)) begin n_bad++; $display("FAIL basic_a_time t=%0d got %0d want %0d", t, ia, a ? 1 : -1); end
         n_cmp++; if (ib !== (b ? int'(1 + G1) : -1)) begin n_bad++; $display("FAIL basic_b_time t=%0d got %0d want %0d", t, ib, b ? int'(1 + G1) : -1); end
         n_cmp++; if (ic !== int'(1 + 2 * G1)) begin n_bad++; $display("FAIL basic_clk_time t=%0d got %0d want %0d", t, ic, 1 + 2 * G1); end
         n_cmp++; if (iv !== int'(1 + 2 * G1 + R1)) begin n_bad++; $display("FAIL basic_valid_time t=%0d got %0d want %0d", t, iv, 1 + 2 * G1 + R1); end
         n_cmp++; if (res !== (a ^ b)) begin n_bad++; $display("FAIL basic_result t=%0d got %0b want %0b", t, res, a ^ b); end
         n_cmp++; if (mm !== 1'b0) begin n_bad++; $display("FAIL basic_mismatch t=%0d got %0b want 0", t, mm); end
         step();
         n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_handshake t=%0d got valid %0b ready %0b want 0 1", t, out_valid, in_ready); end
         if (t == 3) begin
            n_cmp++; if (tx_count !== 16'd4 || err_count !== 16'd0) begin n_bad++; $display("FAIL basic_counts4 got %0d/%0d want 4/0", tx_count, err_count); end
         end
      end
      n_cmp++; if (tx_count !== exp_tx || err_count !== exp_err) begin n_bad++; $display("FAIL basic_counts got %0d/%0d want %0d/%0d", tx_count, err_count, exp_tx, exp_err); end
   endtask

   task automatic test_hold;
      bit a, b, res, mm;
      int ia, ib, ic, iv;
      a = 1'($urandom); b = 1'($urandom);
      out_ready = 1'b0;
      run_txn(a, b, ia, ib, ic, iv, res, mm);
      n_cmp++; if (res !== (a ^ b) || iv < 0) begin n_bad++; $display("FAIL hold_result got %0b (valid idx %0d) want %0b", res, iv, a ^ b); end
      for (int k = 0; k < 10; k++) begin
         if (k == 4) begin in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; end
         if (k == 5) begin in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; end
         step();
         n_cmp++; if (out_valid !== 1'b1 || out_result !== (a ^ b) || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL hold_stable k=%0d got v%0b r%0b rdy%0b want v1 r%0b rdy0", k, out_valid, out_result, in_ready, a ^ b);
         end
      end
      n_cmp++; if (a_out !== a_lvl) begin n_bad++; $display("FAIL hold_no_accept_a got %0b want %0b", a_out, a_lvl); end
      out_ready = 1'b1;
      step();
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release got rdy %0b valid %0b want 1 0", in_ready, out_valid); end
      repeat (3) step();
      n_cmp++; if (tx_count !== exp_tx || in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_count got %0d rdy %0b want %0d 1", tx_count, in_ready, exp_tx); end
   endtask

   task automatic test_faulty_cell;
      bit res, mm;
      int ia, ib, ic, iv;
      faulty = 1'b1;
      run_txn(1'b1, 1'b0, ia, ib, ic, iv, res, mm);
      exp_err = exp_err + 16'd1;
      n_cmp++; if (res !== 1'b0 || mm !== 1'b1) begin n_bad++; $display("FAIL faulty_result got r%0b m%0b want r0 m1", res, mm); end
      n_cmp++; if (err_count !== exp_err || tx_count !== exp_tx) begin n_bad++; $display("FAIL faulty_counts got %0d/%0d want %0d/%0d", tx_count, err_count, exp_tx, exp_err); end
      step();
      faulty = 1'b0;
   endtask

   task automatic test_stray;
      bit res, mm;
      int ia, ib, ic, iv;
      n_cmp++; if (stray_err !== 1'b0) begin n_bad++; $display("FAIL stray_pre got %0b want 0", stray_err); end
      stray_req = stray_req + 1;
      repeat (6) step();
      n_cmp++; if (stray_err !== 1'b1) begin n_bad++; $display("FAIL stray_set got %0b want 1", stray_err); end
      run_txn(1'b0, 1'b1, ia, ib, ic, iv, res, mm);
      n_cmp++; if (res !== 1'b1 || mm !== 1'b0) begin n_bad++; $display("FAIL stray_next_txn got r%0b m%0b want r1 m0", res, mm); end
      step();
      repeat (3) step();
      n_cmp++; if (stray_err !== 1'b1) begin n_bad++; $display("FAIL stray_sticky got %0b want 1", stray_err); end
      n_cmp++; if (err_count !== exp_err) begin n_bad++; $display("FAIL stray_errs got %0d want %0d", err_count, exp_err); end
   endtask

   task automatic test_reset_mid;
      bit a;
      a = ~a_lvl;
      in_valid = 1'b1; in_a = a; in_b = 1'($urandom);
      step();
      in_valid = 1'b0;
      step();
      step();
      n_cmp++; if (a_out !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_pre got a%0b rdy%0b want a1 rdy0", a_out, in_ready); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({a_out, b_out, clk_out} !== 3'b000) begin n_bad++; $display("FAIL mid_lines got %b want 000", {a_out, b_out, clk_out}); end
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || stray_err !== 1'b0) begin n_bad++; $display("FAIL mid_flags got rdy%0b v%0b s%0b want 1 0 0", in_ready, out_valid, stray_err); end
      n_cmp++; if (tx_count !== 16'd0 || err_count !== 16'd0) begin n_bad++; $display("FAIL mid_counts got %0d/%0d want 0/0", tx_count, err_count); end
      a_lvl = 1'b0; exp_tx = '0; exp_err = '0;
      repeat (2) step();
      rst = 1'b0;
      repeat (5) step();
      n_cmp++; if (in_ready !== 1'b1 || {a_out, b_out, clk_out} !== 3'b000) begin n_bad++; $display("FAIL mid_after got rdy%0b lines %b want 1 000", in_ready, {a_out, b_out, clk_out}); end
   endtask

   task automatic test_back_to_back;
      int acc[$];
      bit expq[$];
      int got = 0;
      int guard = 0;
      bit accepting;
      bit e;
      out_ready2 = 1'b1;
      in_valid2 = 1'b1; in_a2 = 1'($urandom); in_b2 = 1'($urandom);
      while ((acc.size() < 3 || got < 3) && guard < 200) begin
         accepting = 1'b0;
         if (in_valid2 && in_ready2) begin
            acc.push_back(cyc + 1);
            expq.push_back(in_a2 ^ in_b2);
            accepting = 1'b1;
         end
         if (out_valid2 === 1'b1) begin
            e = (expq.size() > 0) ? expq.pop_front() : 1'b0;
            n_cmp++; if (out_result2 !== e || out_mismatch2 !== 1'b0) begin n_bad++; $display("FAIL b2b_result n=%0d got r%0b m%0b want r%0b m0", got, out_result2, out_mismatch2, e); end
            got++;
         end
         step();
         guard++;
         if (accepting) begin
            if (acc.size() == 3) in_valid2 = 1'b0;
            in_a2 = 1'($urandom); in_b2 = 1'($urandom);
         end
      end
      in_valid2 = 1'b0;
      n_cmp++; if (guard >= 200) begin n_bad++; $display("FAIL b2b_timeout got %0d accepts %0d results want 3 3", acc.size(), got); end
      n_cmp++;
      if (acc.size() == 3) begin
         if (acc[1] - acc[0] != int'(2 * G2 + R2 + 2) || acc[2] - acc[1] != int'(2 * G2 + R2 + 2)) begin
            n_bad++; $display("FAIL b2b_spacing got %0d,%0d want %0d", acc[1] - acc[0], acc[2] - acc[1], 2 * G2 + R2 + 2);
         end
      end else begin
         n_bad++; $display("FAIL b2b_accepts got %0d want 3", acc.size());
      end
      step();
      n_cmp++; if (tx_count2 !== 16'd3 || err_count2 !== 16'd0) begin n_bad++; $display("FAIL b2b_counts got %0d/%0d want 3/0", tx_count2, err_count2); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_faulty_cell();
      test_stray();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
